// File: rtl/dp_arb_pkg.sv
// -----------------------------------------------------------------------------
// dp_arb_pkg
// Shared types and helpers for the DP23 FIFO write-port arbiter.
//   dp_arb_state_t : arbiter FSM states (IDLE, HDR, DATA)
//   HDR_MARK       : marker byte in the top byte of every packet header
//   build_hdr()    : header word {HDR_MARK, zeros, src_id}, built at full
//                    HDR_MAX_W width; the caller casts it down to its FIFO width
// -----------------------------------------------------------------------------
package dp_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } dp_arb_state_t;

    localparam logic [7:0] HDR_MARK  = 8'hA5;
    // Widest FIFO word the header helper supports.
    localparam int         HDR_MAX_W = 64;

    // The marker lands in the top byte of a 'width'-bit word and the source ID
    // in the bottom byte. The bits in between are zero.
    function automatic logic [HDR_MAX_W-1:0] build_hdr(input int width,
                                                       input logic [7:0] src_id);
        logic [HDR_MAX_W-1:0] h;
        h = (HDR_MAX_W'(HDR_MARK) << (width - 8)) | HDR_MAX_W'(src_id);
        return h;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick. It returns the first requester searching
// upward from ptr+1 and wraps around. ptr itself is checked last.
//   req     : request vector
//   ptr     : index of the previous winner
//   gnt     : one-hot grant (all zero when req == 0)
//   gnt_idx : binary index of the grant (0 when req == 0)
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic          w_found;
    logic [IW-1:0] w_idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 1; k <= N; k++) begin
            w_idx = IW'((int'(ptr) + k) % N);
            if (!w_found && req[w_idx]) begin
                w_found      = 1'b1;
                gnt[w_idx]   = 1'b1;
                gnt_idx      = w_idx;
            end
        end
    end

endmodule

// File: rtl/dp_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// dp_fifo_wr_arbiter
// Packet-granular round-robin arbiter in front of the DP23 data FIFO write
// port. Each granted packet is preceded by a one-word header {A5, 0.., id}.
// Payloads longer than MAX_PKT_WORDS are cut. The rest of the payload is sent
// later as a new packet with its own header.
//   clk_dp_wr_i / rst_n_i : write clock, async active-low reset
//   enable_i              : allows new packets to start (IDLE only)
//   src_mask_i            : per-source eligibility (IDLE only)
//   src_valid/last/data_i : per-source word stream; src i at [i*GpifWidth +: GpifWidth]
//   src_ready_o           : combinational accept for the granted source
//   dpo_full_i / dpo_almst_full_i : FIFO back-pressure; either one blocks a write
//   dpo_wr_o / dpo_dti_o  : registered FIFO write strobe and data
//   grant_o               : one-hot packet owner, 0 in IDLE
//   busy_o                : FSM not in IDLE
//   trunc_o               : one-cycle pulse, aligned with the write of the capped word
// Valid/ready: a word moves when src_valid_i & src_ready_o are both high at a
// rising edge. src_ready_o never depends on itself and may be high only for
// the granted source.
// -----------------------------------------------------------------------------
module dp_fifo_wr_arbiter
    import dp_arb_pkg::*;
#(
    parameter int NUM_SRC       = 4,
    parameter int GpifWidth     = 32,
    parameter int MAX_PKT_WORDS = 256
) (
    input  logic                         clk_dp_wr_i,
    input  logic                         rst_n_i,
    input  logic                         enable_i,
    input  logic [NUM_SRC-1:0]           src_mask_i,
    input  logic [NUM_SRC-1:0]           src_valid_i,
    input  logic [NUM_SRC-1:0]           src_last_i,
    input  logic [NUM_SRC*GpifWidth-1:0] src_data_i,
    output logic [NUM_SRC-1:0]           src_ready_o,
    input  logic                         dpo_full_i,
    input  logic                         dpo_almst_full_i,
    output logic                         dpo_wr_o,
    output logic [GpifWidth-1:0]         dpo_dti_o,
    output logic [NUM_SRC-1:0]           grant_o,
    output logic                         busy_o,
    output logic                         trunc_o
);

    localparam int             IW      = $clog2(NUM_SRC);
    localparam int             CW      = $clog2(MAX_PKT_WORDS + 1);
    localparam logic [CW-1:0]  CAP     = CW'(MAX_PKT_WORDS - 1);
    // Pointer starts at the last source so that source 0 wins first.
    localparam logic [IW-1:0]  PTR_RST = IW'(NUM_SRC - 1);

    dp_arb_state_t        r_state, w_state_nxt;
    logic [IW-1:0]        r_ptr, w_ptr_nxt;
    logic [IW-1:0]        r_gidx, w_gidx_nxt;
    logic [NUM_SRC-1:0]   r_grant, w_grant_nxt;
    logic [CW-1:0]        r_wcnt, w_wcnt_nxt;
    logic                 r_wr, w_wr_nxt;
    logic [GpifWidth-1:0] r_dti, w_dti_nxt;
    logic                 r_trunc, w_trunc_nxt;

    logic [NUM_SRC-1:0]   w_req;
    logic [NUM_SRC-1:0]   w_arb_gnt;
    logic [IW-1:0]        w_arb_idx;
    logic                 w_space;
    logic                 w_sel_valid;
    logic                 w_sel_last;
    logic [GpifWidth-1:0] w_sel_data;
    logic                 w_accept;

    assign w_req       = src_valid_i & src_mask_i & {NUM_SRC{enable_i}};
    assign w_space     = !dpo_almst_full_i && !dpo_full_i;
    assign w_sel_valid = src_valid_i[r_gidx];
    assign w_sel_last  = src_last_i[r_gidx];
    assign w_sel_data  = src_data_i[int'(r_gidx)*GpifWidth +: GpifWidth];
    assign w_accept    = (r_state == DATA) && w_sel_valid && w_space;

    rr_arbiter #(
        .N  (NUM_SRC),
        .IW (IW)
    ) u_rr (
        .req     (w_req),
        .ptr     (r_ptr),
        .gnt     (w_arb_gnt),
        .gnt_idx (w_arb_idx)
    );

    always_ff @(posedge clk_dp_wr_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
            r_ptr   <= PTR_RST;
            r_gidx  <= '0;
            r_grant <= '0;
            r_wcnt  <= '0;
            r_wr    <= 1'b0;
            r_dti   <= '0;
            r_trunc <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_gidx  <= w_gidx_nxt;
            r_grant <= w_grant_nxt;
            r_wcnt  <= w_wcnt_nxt;
            r_wr    <= w_wr_nxt;
            r_dti   <= w_dti_nxt;
            r_trunc <= w_trunc_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_gidx_nxt  = r_gidx;
        w_grant_nxt = r_grant;
        w_wcnt_nxt  = r_wcnt;
        w_wr_nxt    = 1'b0;
        w_dti_nxt   = r_dti;
        w_trunc_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (|w_req) begin
                    w_grant_nxt = w_arb_gnt;
                    w_gidx_nxt  = w_arb_idx;
                    w_ptr_nxt   = w_arb_idx;
                    w_state_nxt = HDR;
                end
            end
            HDR: begin
                w_wcnt_nxt = '0;
                if (w_space) begin
                    w_wr_nxt    = 1'b1;
                    w_dti_nxt   = GpifWidth'(build_hdr(GpifWidth, 8'(r_gidx)));
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                if (w_accept) begin
                    w_wr_nxt   = 1'b1;
                    w_dti_nxt  = w_sel_data;
                    w_wcnt_nxt = r_wcnt + 1'b1;
                    // A last word on the cap is a normal end, so last is checked first.
                    if (w_sel_last) begin
                        w_state_nxt = IDLE;
                        w_grant_nxt = '0;
                    end else if (r_wcnt == CAP) begin
                        w_state_nxt = IDLE;
                        w_grant_nxt = '0;
                        w_trunc_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    assign src_ready_o = w_accept ? r_grant : '0;
    assign dpo_wr_o    = r_wr;
    assign dpo_dti_o   = r_dti;
    assign grant_o     = r_grant;
    assign busy_o      = (r_state != IDLE);
    assign trunc_o     = r_trunc;

endmodule

// File: tb/tb_dp_fifo_wr_arbiter.sv
module tb_dp_fifo_wr_arbiter;

  localparam int NS   = 4;
  localparam int W    = 32;
  localparam int MAXW = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  initial forever #5 clk = ~clk;

  logic              enable_i;
  logic [NS-1:0]     src_mask_i, src_valid_i, src_last_i, src_ready_o;
  logic [NS*W-1:0]   src_data_i;
  logic              dpo_full_i, dpo_almst_full_i, dpo_wr_o, busy_o, trunc_o;
  logic [W-1:0]      dpo_dti_o;
  logic [NS-1:0]     grant_o;

  dp_fifo_wr_arbiter #(.NUM_SRC(NS), .GpifWidth(W), .MAX_PKT_WORDS(MAXW)) dut (
    .clk_dp_wr_i      (clk),
    .rst_n_i          (rst_n),
    .enable_i         (enable_i),
    .src_mask_i       (src_mask_i),
    .src_valid_i      (src_valid_i),
    .src_last_i       (src_last_i),
    .src_data_i       (src_data_i),
    .src_ready_o      (src_ready_o),
    .dpo_full_i       (dpo_full_i),
    .dpo_almst_full_i (dpo_almst_full_i),
    .dpo_wr_o         (dpo_wr_o),
    .dpo_dti_o        (dpo_dti_o),
    .grant_o          (grant_o),
    .busy_o           (busy_o),
    .trunc_o          (trunc_o)
  );

  // source streams: bit W is 'last'
  typedef logic [W:0] word_t;
  word_t src_q[NS][$];

  // control applied at the next falling edge
  logic          ctl_enable, ctl_almst, ctl_full;
  logic [NS-1:0] ctl_mask;

  // counters and observations
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int trunc_cnt = 0;
  int busy_cnt = 0;
  logic [NS-1:0] grant_seen;
  logic          obs_wr;
  logic [NS-1:0] obs_ready;
  logic [W-1:0]  obs_log[$];
  int            obs_cyc[$];
  logic [W-1:0]  exp_q[$];

  // packet-level model: owner of the current packet (-1 = none), payload words
  // sent (-1 = header still owed), last winner, predicted registered outputs
  int           m_owner = -1;
  int           m_sent = -1;
  int           m_last_win = NS - 1;
  logic         m_wr = 1'b0;
  logic [W-1:0] m_dti = '0;
  logic         m_trunc = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_sent = -1; m_last_win = NS - 1;
    m_wr = 1'b0; m_dti = '0; m_trunc = 1'b0;
  endtask

  task automatic drive_heads();
    word_t h;
    for (int i = 0; i < NS; i++) begin
      if (src_q[i].size() > 0) begin
        h = src_q[i][0];
        src_valid_i[i] = 1'b1;
        src_last_i[i]  = h[W];
        src_data_i[i*W +: W] = h[W-1:0];
      end else begin
        src_valid_i[i] = 1'b0;
        src_last_i[i]  = 1'b0;
        src_data_i[i*W +: W] = '0;
      end
    end
  endtask

  // compare current DUT outputs with the model, then advance the model one edge
  task automatic model_check_advance();
    logic [NS-1:0] elig, e_ready, e_grant;
    logic [W-1:0]  hd;
    bit            space;
    int            win, c;
    space   = !dpo_almst_full_i && !dpo_full_i;
    e_grant = (m_owner >= 0) ? NS'(1 << m_owner) : '0;
    e_ready = '0;
    if (m_owner >= 0 && m_sent >= 0 && src_valid_i[m_owner] && space) e_ready = e_grant;
    chk("ready", src_ready_o, e_ready);
    chk("grant", grant_o, e_grant);
    chk("busy", busy_o, (m_owner >= 0));
    chk("wr", dpo_wr_o, m_wr);
    if (m_wr) chk("dti", dpo_dti_o, m_dti);
    chk("trunc", trunc_o, m_trunc);

    m_wr = 1'b0;
    m_trunc = 1'b0;
    if (m_owner < 0) begin
      elig = src_valid_i & src_mask_i & {NS{enable_i}};
      win = -1;
      for (int k = 1; k <= NS; k++) begin
        c = (m_last_win + k) % NS;
        if (win < 0 && elig[c]) win = c;
      end
      if (win >= 0) begin
        m_owner = win; m_last_win = win; m_sent = -1;
      end
    end else if (m_sent < 0) begin
      if (space) begin
        hd = 32'hA500_0000 + W'(m_owner);
        m_wr = 1'b1; m_dti = hd; m_sent = 0;
      end
    end else if (e_ready != '0) begin
      m_wr = 1'b1;
      m_dti = src_data_i[m_owner*W +: W];
      m_sent++;
      if (src_last_i[m_owner]) m_owner = -1;
      else if (m_sent == MAXW) begin
        m_owner = -1; m_trunc = 1'b1;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    enable_i = ctl_enable;
    src_mask_i = ctl_mask;
    dpo_almst_full_i = ctl_almst;
    dpo_full_i = ctl_full;
    drive_heads();
    #1;
    cyc++;
    obs_wr = dpo_wr_o;
    obs_ready = src_ready_o;
    if (dpo_wr_o) begin
      obs_log.push_back(dpo_dti_o);
      obs_cyc.push_back(cyc);
    end
    if (trunc_o) trunc_cnt++;
    busy_cnt += int'(busy_o);
    grant_seen |= grant_o;
    model_check_advance();
    for (int i = 0; i < NS; i++)
      if (src_ready_o[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
  endtask

  function automatic bit quiet();
    if (m_owner >= 0 || m_wr) return 1'b0;
    for (int i = 0; i < NS; i++)
      if (src_q[i].size() > 0 && ctl_mask[i] && ctl_enable) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget; c++) begin
      step();
      if (quiet()) begin
        done = 1'b1;
        break;
      end
    end
    chk({name, "_drain_done"}, done, 1'b1);
  endtask

  task automatic push(input int s, input logic [W-1:0] d, input logic last);
    src_q[s].push_back({last, d});
  endtask

  task automatic check_log(input string name);
    int n;
    chk({name, "_count"}, obs_log.size(), exp_q.size());
    n = (obs_log.size() < exp_q.size()) ? obs_log.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_word%0d", name, i), obs_log[i], exp_q[i]);
  endtask

  task automatic clear_obs();
    obs_log.delete();
    obs_cyc.delete();
    trunc_cnt = 0;
    busy_cnt = 0;
    grant_seen = '0;
  endtask

  int start_cyc;

  initial begin
    ctl_enable = 1'b1; ctl_mask = '1; ctl_almst = 1'b0; ctl_full = 1'b0;
    enable_i = 1'b1; src_mask_i = '1; dpo_almst_full_i = 1'b0; dpo_full_i = 1'b0;
    src_valid_i = '0; src_last_i = '0; src_data_i = '0;
    grant_seen = '0;

    // reset values
    #3;
    chk("rst_wr", dpo_wr_o, 1'b0);
    chk("rst_dti", dpo_dti_o, 32'h0);
    chk("rst_grant", grant_o, 4'h0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_trunc", trunc_o, 1'b0);
    chk("rst_ready", src_ready_o, 4'h0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // round robin: 0,1,2,3 then 0 again
    clear_obs();
    push(0, 32'h100, 1'b1); push(0, 32'h200, 1'b1);
    push(1, 32'h101, 1'b1); push(2, 32'h102, 1'b1); push(3, 32'h103, 1'b1);
    drain("rr", 80);
    exp_q = '{32'hA500_0000, 32'h100, 32'hA500_0001, 32'h101, 32'hA500_0002, 32'h102,
              32'hA500_0003, 32'h103, 32'hA500_0000, 32'h200};
    check_log("rr");

    // single 3-word packet from src0
    clear_obs();
    push(0, 32'h11, 1'b0); push(0, 32'h22, 1'b0); push(0, 32'h33, 1'b1);
    start_cyc = cyc;
    drain("single", 40);
    exp_q = '{32'hA500_0000, 32'h11, 32'h22, 32'h33};
    check_log("single");
    chk("single_grant", grant_seen, 4'b0001);
    chk("single_busy_cycles", busy_cnt, 4);
    if (obs_cyc.size() >= 4) begin
      chk("single_hdr_latency", obs_cyc[0] - start_cyc, 3);
      chk("single_consecutive", obs_cyc[3] - obs_cyc[0], 3);
    end else chk("single_wr_cycles", obs_cyc.size(), 4);

    // almost-full for 4 cycles mid-packet; 4 words with last on the cap
    clear_obs();
    push(1, 32'hB1, 1'b0); push(1, 32'hB2, 1'b0); push(1, 32'hB3, 1'b0); push(1, 32'hB4, 1'b1);
    repeat (4) step();
    ctl_almst = 1'b1;
    step();
    chk("bp_ready0", obs_ready, 4'h0);
    for (int j = 1; j < 4; j++) begin
      step();
      chk($sformatf("bp_ready%0d", j), obs_ready, 4'h0);
      chk($sformatf("bp_wr%0d", j), obs_wr, 1'b0);
    end
    ctl_almst = 1'b0;
    step();
    chk("bp_wr4", obs_wr, 1'b0);
    drain("bp", 40);
    exp_q = '{32'hA500_0001, 32'hB1, 32'hB2, 32'hB3, 32'hB4};
    check_log("bp");
    chk("bp_no_trunc", trunc_cnt, 0);

    // truncation of a 6-word packet at 4 words, with a full cycle in HDR
    clear_obs();
    for (int j = 1; j <= 6; j++) push(2, W'(32'h30 + j), (j == 6));
    step();
    ctl_full = 1'b1;
    step();
    ctl_full = 1'b0;
    drain("trunc", 60);
    exp_q = '{32'hA500_0002, 32'h31, 32'h32, 32'h33, 32'h34,
              32'hA500_0002, 32'h35, 32'h36};
    check_log("trunc");
    chk("trunc_pulses", trunc_cnt, 1);

    // mask cleared mid-packet: packet completes, src1 skipped afterwards
    clear_obs();
    push(1, 32'h41, 1'b0); push(1, 32'h42, 1'b0); push(1, 32'h43, 1'b1);
    repeat (2) step();
    push(3, 32'h61, 1'b1);
    push(1, 32'h51, 1'b1);
    ctl_mask = 4'b1101;
    drain("mask", 60);
    exp_q = '{32'hA500_0001, 32'h41, 32'h42, 32'h43, 32'hA500_0003, 32'h61};
    check_log("mask");

    // enable low in IDLE: no grant
    clear_obs();
    ctl_mask = '1;
    ctl_enable = 1'b0;
    for (int j = 0; j < 6; j++) begin
      step();
      chk($sformatf("en_off_grant%0d", j), grant_o, 4'h0);
    end
    ctl_enable = 1'b1;
    drain("enable", 40);
    exp_q = '{32'hA500_0001, 32'h51};
    check_log("enable");

    // async reset in the middle of DATA
    clear_obs();
    for (int j = 1; j <= 5; j++) push(0, W'(32'h70 + j), (j == 5));
    repeat (4) step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wr", dpo_wr_o, 1'b0);
    chk("arst_grant", grant_o, 4'h0);
    chk("arst_busy", busy_o, 1'b0);
    chk("arst_ready", src_ready_o, 4'h0);
    model_reset();
    for (int i = 0; i < NS; i++) src_q[i].delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    clear_obs();
    push(1, 32'h91, 1'b1);
    push(0, 32'h81, 1'b1);
    drain("arst", 40);
    exp_q = '{32'hA500_0000, 32'h81, 32'hA500_0001, 32'h91};
    check_log("arst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
